// File: rtl/regfile_2w2r_sb.sv
// Two-write, two-read register file with write-to-read bypass and a per-register
// pending-write scoreboard for the issue stage. Port A is the younger writer.
module regfile_2w2r_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam bit          HasZero = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic              wen_a, wen_b, iss_ok;

  // Qualified enables: register 0 swallows writes and issues when hardwired to zero.
  always_comb begin
    wen_a  = we_a && !(HasZero && (wa_a == '0));
    wen_b  = we_b && !(HasZero && (wa_b == '0));
    iss_ok = iss_en && !(HasZero && (iss_rd == '0));
  end

  // Array update; B is applied first so A (younger) wins on an address collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wen_b) mem_q[wa_b] <= wd_b;
      if (wen_a) mem_q[wa_a] <= wd_a;
    end
  end

  // Scoreboard next state: completions clear, then an issue sets (a new producer wins).
  always_comb begin
    busy_d = busy_q;
    if (wen_a)  busy_d[wa_a]   = 1'b0;
    if (wen_b)  busy_d[wa_b]   = 1'b0;
    if (iss_ok) busy_d[iss_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Identical read logic for both ports.
  for (genvar p = 0; p < 2; p++) begin : g_read
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;
    logic              hit_a, hit_b, is_zero;

    assign raddr = (p == 0) ? ra1 : ra2;

    // Bypass current-cycle writes; a value delivered this cycle never reads as busy.
    always_comb begin
      hit_a   = wen_a && (wa_a == raddr);
      hit_b   = wen_b && (wa_b == raddr);
      is_zero = HasZero && (raddr == '0);
      if (!rstn || is_zero) begin
        rdata = '0;
      end else if (hit_a) begin
        rdata = wd_a;
      end else if (hit_b) begin
        rdata = wd_b;
      end else begin
        rdata = mem_q[raddr];
      end
      rbusy = rstn && !is_zero && busy_q[raddr] && !(hit_a || hit_b);
    end
  end

  assign rd1   = g_read[0].rdata;
  assign rd2   = g_read[1].rdata;
  assign busy1 = g_read[0].rbusy;
  assign busy2 = g_read[1].rbusy;

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Bench for regfile_2w2r_sb: directed scenarios plus a constrained-random run, all
// checked through a queue of expected read-port values.
module tb_regfile_2w2r_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] ra1, ra2, wa_a, wa_b, iss_rd;
  logic [DW-1:0] rd1, rd2, wd_a, wd_b;
  logic          busy1, busy2, we_a, we_b, iss_en;

  typedef struct {
    string         tag;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          b1;
    logic          b2;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] m_mem [32];
  logic          m_busy [32];

  regfile_2w2r_sb #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .busy1 (busy1),
    .busy2 (busy2),
    .we_a  (we_a),
    .wa_a  (wa_a),
    .wd_a  (wd_a),
    .we_b  (we_b),
    .wa_b  (wa_b),
    .wd_b  (wd_b),
    .iss_en(iss_en),
    .iss_rd(iss_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                      input logic eb1, input logic eb2);
    exp_t e;
    e.tag = tag;
    e.rd1 = e1;
    e.rd2 = e2;
    e.b1  = eb1;
    e.b2  = eb2;
    sbq.push_back(e);
  endtask

  task automatic idle();
    we_a   = 1'b0;
    we_b   = 1'b0;
    iss_en = 1'b0;
    wa_a   = '0;
    wa_b   = '0;
    wd_a   = '0;
    wd_b   = '0;
    iss_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held: every address reads 0/not busy even with writes and issues presented.
  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 33; c++) begin
      idle();
      if (c < 32) begin
        we_a   = 1'b1;
        wa_a   = AW'(c);
        wd_a   = 32'hFFFF_FFFF;
        we_b   = 1'b1;
        wa_b   = AW'(c);
        wd_b   = 32'h5A5A_5A5A;
        iss_en = 1'b1;
        iss_rd = AW'(c);
        ra1    = AW'(c);
        ra2    = AW'(31 - c);
        push("reset_read", '0, '0, 1'b0, 1'b0);
      end else begin
        rstn = 1'b1;
        ra1  = 5'd1;
        ra2  = 5'd31;
        push("after_reset", '0, '0, 1'b0, 1'b0);
      end
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      ra1 = 5'd5;
      ra2 = 5'd6;
      case (c)
        0: begin
          we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF;
          push("bypass_a", 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
        end
        1: push("array_a", 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
        2: begin
          we_b = 1'b1; wa_b = 5'd6; wd_b = 32'h6666_6666;
          push("bypass_b", 32'hDEAD_BEEF, 32'h6666_6666, 1'b0, 1'b0);
        end
        default: push("array_b", 32'hDEAD_BEEF, 32'h6666_6666, 1'b0, 1'b0);
      endcase
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  task automatic test_dual_write();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: begin
          we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1111;
          we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h2222;
          ra1 = 5'd7; ra2 = 5'd7;
          push("collide_bypass", 32'h1111, 32'h1111, 1'b0, 1'b0);
        end
        1: begin
          ra1 = 5'd7; ra2 = 5'd7;
          push("collide_array", 32'h1111, 32'h1111, 1'b0, 1'b0);
        end
        2: begin
          we_a = 1'b1; wa_a = 5'd8;  wd_a = 32'hAAAA;
          we_b = 1'b1; wa_b = 5'd12; wd_b = 32'hBBBB;
          ra1 = 5'd12; ra2 = 5'd8;
          push("split_bypass", 32'hBBBB, 32'hAAAA, 1'b0, 1'b0);
        end
        default: begin
          ra1 = 5'd12; ra2 = 5'd8;
          push("split_array", 32'hBBBB, 32'hAAAA, 1'b0, 1'b0);
        end
      endcase
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      idle();
      ra1 = 5'd9;
      ra2 = 5'd10;
      case (c)
        0: begin
          iss_en = 1'b1; iss_rd = 5'd9;
          push("issue_same_cycle", '0, '0, 1'b0, 1'b0);
        end
        1: begin
          iss_en = 1'b1; iss_rd = 5'd10;
          push("busy_after_issue", '0, '0, 1'b1, 1'b0);
        end
        2: begin
          iss_en = 1'b1; iss_rd = 5'd9;
          push("reissue_busy", '0, '0, 1'b1, 1'b1);
        end
        3: begin
          we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h9999;
          push("complete_b", 32'h9999, '0, 1'b0, 1'b1);
        end
        4: begin
          we_a = 1'b1; wa_a = 5'd10; wd_a = 32'h1010;
          push("complete_a", 32'h9999, 32'h1010, 1'b0, 1'b0);
        end
        default: push("cleared", 32'h9999, 32'h1010, 1'b0, 1'b0);
      endcase
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  task automatic test_set_wins();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      ra1 = 5'd3;
      ra2 = 5'd3;
      case (c)
        0: begin
          iss_en = 1'b1; iss_rd = 5'd3;
          we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h3333;
          push("set_clear_same", 32'h3333, 32'h3333, 1'b0, 1'b0);
        end
        1: push("set_wins", 32'h3333, 32'h3333, 1'b1, 1'b1);
        2: begin
          we_b = 1'b1; wa_b = 5'd3; wd_b = 32'h4444;
          push("set_then_clear", 32'h4444, 32'h4444, 1'b0, 1'b0);
        end
        default: push("set_cleared", 32'h4444, 32'h4444, 1'b0, 1'b0);
      endcase
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      idle();
      ra1 = 5'd0;
      if (c == 0) begin
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF;
        we_b = 1'b1; wa_b = 5'd0; wd_b = 32'h1234_5678;
        iss_en = 1'b1; iss_rd = 5'd0;
        ra2 = 5'd0;
        push("zero_write", '0, '0, 1'b0, 1'b0);
      end else begin
        ra2 = 5'd5;
        push("zero_after", '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      end
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  // Reset pulsed while a write is in flight and a register is busy.
  task automatic test_reset_midstream();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      idle();
      ra1 = 5'd5;
      ra2 = 5'd11;
      case (c)
        0: begin
          iss_en = 1'b1; iss_rd = 5'd11;
          push("pre_reset", 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
        end
        1: push("pre_reset_busy", 32'hDEAD_BEEF, '0, 1'b0, 1'b1);
        2: begin
          we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h5555_5555;
          iss_en = 1'b1; iss_rd = 5'd5;
          rstn = 1'b0;
          push("in_reset", '0, '0, 1'b0, 1'b0);
        end
        3: begin
          rstn = 1'b1;
          push("post_reset", '0, '0, 1'b0, 1'b0);
        end
        default: begin
          ra1 = 5'd7; ra2 = 5'd3;
          push("post_reset_other", '0, '0, 1'b0, 1'b0);
        end
      endcase
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      step();
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (we_a && wa_a == ra) return wd_a;
    if (we_b && wa_b == ra) return wd_b;
    return m_mem[ra];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] ra);
    if (ra == 0) return 1'b0;
    if ((we_a && wa_a == ra) || (we_b && wa_b == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  // Random traffic on a small address window to force collisions; starts from a cleared file.
  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    for (int c = 0; c < 200; c++) begin
      we_a   = 1'($urandom_range(0, 1));
      we_b   = 1'($urandom_range(0, 1));
      iss_en = 1'($urandom_range(0, 1));
      wa_a   = AW'($urandom_range(0, 7));
      wa_b   = AW'($urandom_range(0, 7));
      iss_rd = AW'($urandom_range(0, 7));
      ra1    = AW'($urandom_range(0, 7));
      ra2    = AW'($urandom_range(0, 7));
      wd_a   = $urandom;
      wd_b   = $urandom;
      push("random", model_rd(ra1), model_rd(ra2), model_busy(ra1), model_busy(ra2));
      #4;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || busy1 !== e.b1 || busy2 !== e.b2) begin
          errors++;
          $display("FAIL %s cycle %0d: got rd1=%h rd2=%h busy1=%b busy2=%b, want rd1=%h rd2=%h busy1=%b busy2=%b",
                   e.tag, c, rd1, rd2, busy1, busy2, e.rd1, e.rd2, e.b1, e.b2);
        end
      end
      if (we_b && wa_b != 0) begin
        m_mem[wa_b]  = wd_b;
        m_busy[wa_b] = 1'b0;
      end
      if (we_a && wa_a != 0) begin
        m_mem[wa_a]  = wd_a;
        m_busy[wa_a] = 1'b0;
      end
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    ra1 = '0;
    ra2 = '0;
    #1;
    test_reset();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_set_wins();
    test_zero_reg();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
